// File: rtl/riscv_ctrl.sv
// rtl/riscv_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RISC-V datapath
module riscv_ctrl #(
    parameter int KIND_W = 4,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [KIND_W-1:0] kind,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              cmp_true,
    output logic              ir_we,
    output logic              sel_alu0,
    output logic              sel_alu1,
    output logic [OP_W-1:0]   alu_op,
    output logic              sel_ex,
    output logic              sel_res,
    output logic              sel_rf_wr,
    output logic              sel_pc,
    output logic              pc_we,
    output logic              dmem_wr_en,
    output logic              retire,
    output logic              halted,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [KIND_W-1:0] K_R      = KIND_W'(0);
    localparam logic [KIND_W-1:0] K_I_ALU  = KIND_W'(1);
    localparam logic [KIND_W-1:0] K_LOAD   = KIND_W'(2);
    localparam logic [KIND_W-1:0] K_STORE  = KIND_W'(3);
    localparam logic [KIND_W-1:0] K_BRANCH = KIND_W'(4);
    localparam logic [KIND_W-1:0] K_JAL    = KIND_W'(5);
    localparam logic [KIND_W-1:0] K_JALR   = KIND_W'(6);
    localparam logic [KIND_W-1:0] K_LUI    = KIND_W'(7);
    localparam logic [KIND_W-1:0] K_AUIPC  = KIND_W'(8);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(8);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_PASSB = OP_W'(10);

    state_t            state_q, state_d;
    logic [KIND_W-1:0] kind_q;
    logic [2:0]        f3_q;
    logic [6:0]        f7_q;
    logic              halted_q;
    logic              kind_legal;
    logic              unused_f7;

    // Only funct7[5] steers the ALU; the remaining bits are latched for completeness.
    assign unused_f7  = &{1'b0, f7_q[6], f7_q[4:0]};
    assign kind_legal = (kind <= K_AUIPC);

    function automatic logic [OP_W-1:0] funct_op(input logic [2:0] f3, input logic alt,
                                                 input logic sub_ok);
        case (f3)
            3'b000:  return (alt && sub_ok) ? OP_SUB : OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return alt ? OP_SRA : OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            halted_q <= 1'b0;
            kind_q   <= '0;
            f3_q     <= '0;
            f7_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                kind_q <= kind;
                f3_q   <= funct3;
                f7_q   <= funct7;
            end
            if (state_d == S_HALT) begin
                halted_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = kind_legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (kind_q == K_BRANCH)                          state_d = S_FETCH;
                else if (kind_q == K_LOAD || kind_q == K_STORE)  state_d = S_MEM;
                else                                             state_d = S_WB;
            end
            S_MEM:    state_d = (kind_q == K_LOAD) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Reset forces every output low in the same cycle, so an aborted instruction never commits.
    always_comb begin
        ir_we      = 1'b0;
        sel_alu0   = 1'b0;
        sel_alu1   = 1'b0;
        alu_op     = OP_ADD;
        sel_ex     = 1'b0;
        sel_res    = 1'b0;
        sel_rf_wr  = 1'b0;
        sel_pc     = 1'b0;
        pc_we      = 1'b0;
        dmem_wr_en = 1'b0;
        retire     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: ir_we = 1'b1;
                S_EXEC: begin
                    case (kind_q)
                        K_R:     alu_op = funct_op(f3_q, f7_q[5], 1'b1);
                        K_I_ALU: begin
                            sel_alu1 = 1'b1;
                            alu_op   = funct_op(f3_q, f7_q[5], 1'b0);
                        end
                        K_LOAD, K_STORE, K_JALR: sel_alu1 = 1'b1;
                        K_JAL, K_AUIPC: begin
                            sel_alu0 = 1'b1;
                            sel_alu1 = 1'b1;
                        end
                        K_LUI: begin
                            sel_alu1 = 1'b1;
                            alu_op   = OP_PASSB;
                        end
                        K_BRANCH: begin
                            sel_alu0 = 1'b1;
                            sel_alu1 = 1'b1;
                            pc_we    = 1'b1;
                            sel_pc   = cmp_true;
                            retire   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (kind_q == K_STORE) begin
                        dmem_wr_en = 1'b1;
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                    end
                end
                S_WB: begin
                    sel_rf_wr = 1'b1;
                    pc_we     = 1'b1;
                    retire    = 1'b1;
                    sel_res   = (kind_q == K_LOAD);
                    if (kind_q == K_JAL || kind_q == K_JALR) begin
                        sel_ex = 1'b1;
                        sel_pc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state  = reset ? 3'd0 : 3'(state_q);
    assign halted = halted_q & ~reset;

endmodule

// File: tb/tb_riscv_ctrl.sv
// tb/tb_riscv_ctrl.sv - scoreboard bench for riscv_ctrl with directed per-cycle vectors
module tb_riscv_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] kind = 4'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       cmp_true = 1'b0;
    logic       ir_we, sel_alu0, sel_alu1, sel_ex, sel_res, sel_rf_wr, sel_pc, pc_we;
    logic       dmem_wr_en, retire, halted;
    logic [3:0] alu_op;
    logic [2:0] state;

    riscv_ctrl #(.KIND_W(4), .OP_W(4)) dut (
        .clk(clk), .reset(reset), .kind(kind), .funct3(funct3), .funct7(funct7),
        .cmp_true(cmp_true), .ir_we(ir_we), .sel_alu0(sel_alu0), .sel_alu1(sel_alu1),
        .alu_op(alu_op), .sel_ex(sel_ex), .sel_res(sel_res), .sel_rf_wr(sel_rf_wr),
        .sel_pc(sel_pc), .pc_we(pc_we), .dmem_wr_en(dmem_wr_en), .retire(retire),
        .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [17:0] IRW = 18'h1 << 0;
    localparam logic [17:0] A0  = 18'h1 << 1;
    localparam logic [17:0] A1  = 18'h1 << 2;
    localparam logic [17:0] EX  = 18'h1 << 7;
    localparam logic [17:0] RES = 18'h1 << 8;
    localparam logic [17:0] RF  = 18'h1 << 9;
    localparam logic [17:0] PCS = 18'h1 << 10;
    localparam logic [17:0] PCW = 18'h1 << 11;
    localparam logic [17:0] DW  = 18'h1 << 12;
    localparam logic [17:0] RET = 18'h1 << 13;
    localparam logic [17:0] HLT = 18'h1 << 14;

    function automatic logic [17:0] st(input int s);
        return 18'(s) << 15;
    endfunction

    function automatic logic [17:0] op(input int o);
        return 18'(o) << 3;
    endfunction

    typedef struct {
        string       nm;
        logic [17:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    wire [17:0] act = {state, halted, retire, dmem_wr_en, pc_we, sel_pc, sel_rf_wr,
                       sel_res, sel_ex, alu_op, sel_alu1, sel_alu0, ir_we};

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            vectors++;
            if (act !== e.v) begin
                miscompares++;
                $display("FAIL %s: got %05h expected %05h (state %0d vs %0d)",
                         e.nm, act, e.v, act[17:15], e.v[17:15]);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic [3:0] k,
                        input logic [2:0] f3, input logic [6:0] f7, input logic c,
                        input logic [17:0] e);
        @(posedge clk);
        #1;
        reset    = r;
        kind     = k;
        funct3   = f3;
        funct7   = f7;
        cmp_true = c;
        sb_q.push_back('{nm, e});
    endtask

    initial begin
        step("rst0", 1'b1, 4'd0, 3'd0, 7'd0, 1'b0, 18'h0);
        step("rst1", 1'b1, 4'd0, 3'd0, 7'd0, 1'b0, 18'h0);

        // R-type SUB; inputs scrambled after DECODE must not disturb EXEC/WB
        step("sub_fetch",  1'b0, 4'd15, 3'd7, 7'h7f, 1'b0, st(0) | IRW);
        step("sub_decode", 1'b0, 4'd0,  3'd0, 7'h20, 1'b0, st(1));
        step("sub_exec",   1'b0, 4'd7,  3'd5, 7'h00, 1'b1, st(2) | op(1));
        step("sub_wb",     1'b0, 4'd3,  3'd1, 7'h00, 1'b0, st(4) | RF | PCW | RET);

        // I_ALU: funct7[5] never yields SUB, but does yield SRA
        step("iadd_fetch",  1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(0) | IRW);
        step("iadd_decode", 1'b0, 4'd1, 3'd0, 7'h20, 1'b0, st(1));
        step("iadd_exec",   1'b0, 4'd1, 3'd0, 7'h20, 1'b0, st(2) | A1 | op(0));
        step("iadd_wb",     1'b0, 4'd1, 3'd0, 7'h20, 1'b0, st(4) | RF | PCW | RET);
        step("isra_fetch",  1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(0) | IRW);
        step("isra_decode", 1'b0, 4'd1, 3'd5, 7'h20, 1'b0, st(1));
        step("isra_exec",   1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(2) | A1 | op(7));
        step("isra_wb",     1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(4) | RF | PCW | RET);

        // LOAD (5 cycles) then STORE (4 cycles)
        step("ld_fetch",  1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(0) | IRW);
        step("ld_decode", 1'b0, 4'd2, 3'd2, 7'h00, 1'b0, st(1));
        step("ld_exec",   1'b0, 4'd3, 3'd0, 7'h00, 1'b0, st(2) | A1);
        step("ld_mem",    1'b0, 4'd3, 3'd0, 7'h00, 1'b0, st(3));
        step("ld_wb",     1'b0, 4'd3, 3'd0, 7'h00, 1'b0, st(4) | RF | PCW | RET | RES);
        step("st_fetch",  1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(0) | IRW);
        step("st_decode", 1'b0, 4'd3, 3'd2, 7'h00, 1'b0, st(1));
        step("st_exec",   1'b0, 4'd2, 3'd0, 7'h00, 1'b0, st(2) | A1);
        step("st_mem",    1'b0, 4'd2, 3'd0, 7'h00, 1'b0, st(3) | DW | PCW | RET);

        // BRANCH taken then not taken, 3 cycles each
        step("bt_fetch",  1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(0) | IRW);
        step("bt_decode", 1'b0, 4'd4, 3'd0, 7'h00, 1'b0, st(1));
        step("bt_exec",   1'b0, 4'd0, 3'd0, 7'h00, 1'b1, st(2) | A0 | A1 | PCW | PCS | RET);
        step("bn_fetch",  1'b0, 4'd0, 3'd0, 7'h00, 1'b1, st(0) | IRW);
        step("bn_decode", 1'b0, 4'd4, 3'd1, 7'h00, 1'b1, st(1));
        step("bn_exec",   1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(2) | A0 | A1 | PCW | RET);

        // JAL and LUI
        step("jal_fetch",  1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(0) | IRW);
        step("jal_decode", 1'b0, 4'd5, 3'd0, 7'h00, 1'b0, st(1));
        step("jal_exec",   1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(2) | A0 | A1);
        step("jal_wb",     1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(4) | EX | PCS | RF | PCW | RET);
        step("lui_fetch",  1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(0) | IRW);
        step("lui_decode", 1'b0, 4'd7, 3'd0, 7'h00, 1'b0, st(1));
        step("lui_exec",   1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(2) | A1 | op(10));
        step("lui_wb",     1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(4) | RF | PCW | RET);

        // Reset during MEM of a STORE aborts it
        step("abort_fetch",  1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(0) | IRW);
        step("abort_decode", 1'b0, 4'd3, 3'd0, 7'h00, 1'b0, st(1));
        step("abort_exec",   1'b0, 4'd3, 3'd0, 7'h00, 1'b0, st(2) | A1);
        step("abort_mem",    1'b1, 4'd3, 3'd0, 7'h00, 1'b0, 18'h0);
        step("abort_refetch", 1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(0) | IRW);
        step("abort_decode2", 1'b0, 4'd1, 3'd4, 7'h00, 1'b0, st(1));
        step("abort_exec2",  1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(2) | A1 | op(5));
        step("abort_wb2",    1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(4) | RF | PCW | RET);

        // Illegal kind: sticky HALT until reset
        step("ill_fetch",  1'b0, 4'd0,  3'd0, 7'h00, 1'b0, st(0) | IRW);
        step("ill_decode", 1'b0, 4'd15, 3'd0, 7'h00, 1'b0, st(1));
        for (int i = 0; i < 10; i++) begin
            step($sformatf("halt_%0d", i), 1'b0, 4'(i), 3'(i), 7'h20, i[0], st(5) | HLT);
        end
        step("halt_reset",   1'b1, 4'd0, 3'd0, 7'h00, 1'b0, 18'h0);
        step("halt_refetch", 1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(0) | IRW);
        step("halt_decode2", 1'b0, 4'd0, 3'd0, 7'h00, 1'b0, st(1));

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
